// File: rtl/phy_rx_align_if.sv
// Lane-side bus of the multi-lane serial receiver: serial bits in, aligned words out.
interface phy_rx_align_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = 8
);
  logic [LANES-1:0]       serial_in;
  logic [LANES*WIDTH-1:0] data_out;
  logic [LANES-1:0]       valid_out;
  logic [LANES-1:0]       active;
  logic                   all_active;

  // Source of serial bits / consumer of recovered words.
  modport master (
    output serial_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  all_active
  );

  // The receiver itself.
  modport slave (
    input  serial_in,
    output data_out,
    output valid_out,
    output active,
    output all_active
  );
endinterface

// File: rtl/phy_rx_align.sv
// Multi-lane serial receiver: per-lane MSB-first deserialiser with comma-based
// word alignment, lock/loss hysteresis and a one-cycle strobe per data word.
module phy_rx_align #(
  parameter int unsigned      LANES      = 2,
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      LOSS_COUNT = 3
) (
  input  logic          clk_8f,
  input  logic          reset_L,
  input  logic          enable,
  phy_rx_align_if.slave bus
);

  localparam int unsigned     CNTW    = $clog2(WIDTH);
  localparam int unsigned     CCW     = $clog2(LOCK_COUNT + 1);
  localparam int unsigned     LCW     = $clog2(LOSS_COUNT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t                 state_q [LANES];
  state_t                 state_d [LANES];
  logic [WIDTH-1:0]       shreg_q [LANES];
  logic [WIDTH-1:0]       shreg_d [LANES];
  logic [CNTW-1:0]        cnt_q   [LANES];
  logic [CNTW-1:0]        cnt_d   [LANES];
  logic [CCW-1:0]         ccnt_q  [LANES];
  logic [CCW-1:0]         ccnt_d  [LANES];
  logic [LCW-1:0]         lcnt_q  [LANES];
  logic [LCW-1:0]         lcnt_d  [LANES];
  logic [LANES*WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]       valid_q, valid_d;
  logic [LANES-1:0]       active_q, active_d;
  logic [WIDTH-1:0]       nxt;
  logic                   at_bound;

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.active     = active_q;
  assign bus.all_active = &active_q;

  // Per-lane next-state: shifting, bit counting, alignment FSM and word delivery.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    ccnt_d   = ccnt_q;
    lcnt_d   = lcnt_q;
    data_d   = data_q;
    valid_d  = '0;
    active_d = active_q;
    nxt      = '0;
    at_bound = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      nxt        = {shreg_q[i][WIDTH-2:0], bus.serial_in[i]};
      at_bound   = (cnt_q[i] == CNT_MAX) && (state_q[i] != SEARCH);
      shreg_d[i] = nxt;
      cnt_d[i]   = (cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
      if (!enable) begin
        state_d[i]  = SEARCH;
        cnt_d[i]    = '0;
        ccnt_d[i]   = '0;
        lcnt_d[i]   = '0;
        active_d[i] = 1'b0;
      end else begin
        unique case (state_q[i])
          SEARCH: begin
            if (nxt == COMMA) begin
              cnt_d[i]  = '0;
              ccnt_d[i] = CCW'(1);
              if (LOCK_COUNT == 1) begin
                state_d[i]  = LOCKED;
                lcnt_d[i]   = '0;
                active_d[i] = 1'b1;
              end else begin
                state_d[i] = ALIGN;
              end
            end
          end
          ALIGN: begin
            if (at_bound) begin
              if (nxt == COMMA) begin
                ccnt_d[i] = ccnt_q[i] + 1'b1;
                if (32'(ccnt_q[i]) + 32'd1 == LOCK_COUNT) begin
                  state_d[i]  = LOCKED;
                  lcnt_d[i]   = '0;
                  active_d[i] = 1'b1;
                end
              end else begin
                state_d[i] = SEARCH;
                ccnt_d[i]  = '0;
              end
            end
          end
          LOCKED: begin
            if (at_bound) begin
              if (nxt == COMMA) begin
                lcnt_d[i] = '0;
              end else begin
                data_d[i*WIDTH +: WIDTH] = nxt;
                valid_d[i]               = 1'b1;
              end
            end else if (nxt == COMMA) begin
              // Drop on the detection that reaches LOSS_COUNT; no re-search this edge.
              if (32'(lcnt_q[i]) + 32'd1 >= LOSS_COUNT) begin
                state_d[i]  = SEARCH;
                lcnt_d[i]   = '0;
                ccnt_d[i]   = '0;
                active_d[i] = 1'b0;
              end else begin
                lcnt_d[i] = lcnt_q[i] + 1'b1;
              end
            end
          end
          default: begin
            state_d[i]  = SEARCH;
            active_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        state_q[i] <= SEARCH;
        shreg_q[i] <= '0;
        cnt_q[i]   <= '0;
        ccnt_q[i]  <= '0;
        lcnt_q[i]  <= '0;
      end
      data_q   <= '0;
      valid_q  <= '0;
      active_q <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        shreg_q[i] <= shreg_d[i];
        cnt_q[i]   <= cnt_d[i];
        ccnt_q[i]  <= ccnt_d[i];
        lcnt_q[i]  <= lcnt_d[i];
      end
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_phy_rx_align.sv
// Testbench for phy_rx_align: queued per-lane bit streams (directed + random)
// checked every cycle against a word/phase-based reference model.
module tb_phy_rx_align;
  localparam int unsigned      LANES      = 2;
  localparam int unsigned      WIDTH      = 8;
  localparam int unsigned      LOCK_COUNT = 4;
  localparam int unsigned      LOSS_COUNT = 3;
  localparam logic [WIDTH-1:0] COMMA      = 8'hBC;
  localparam int unsigned      WMASK      = (1 << WIDTH) - 1;
  localparam int M_SEARCH = 0, M_ALIGN = 1, M_LOCKED = 2;

  logic clk_8f  = 1'b0;
  logic reset_L = 1'b0;
  logic enable  = 1'b0;

  phy_rx_align_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  phy_rx_align #(
    .LANES(LANES), .WIDTH(WIDTH), .COMMA(COMMA),
    .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)
  ) dut (
    .clk_8f (clk_8f),
    .reset_L(reset_L),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk_8f = ~clk_8f;

  int checks = 0;
  int errors = 0;

  // Reference model state: last WIDTH received bits, mode, and the edge index
  // at which word alignment was last acquired (boundaries every WIDTH edges).
  int unsigned            edge_t = 0;
  int unsigned            m_bits  [LANES];
  int                     m_mode  [LANES];
  int unsigned            m_comma [LANES];
  int unsigned            m_loss  [LANES];
  int unsigned            m_anchor[LANES];
  logic [LANES*WIDTH-1:0] exp_data;
  logic [LANES-1:0]       exp_valid;
  logic [LANES-1:0]       exp_active;

  bit lane_q [LANES][$];

  // Per-phase observations.
  int unsigned      pcyc;
  int unsigned      rise_cyc  [LANES];
  int unsigned      first_vcyc[LANES];
  int unsigned      vcount    [LANES];
  int unsigned      last_word [LANES];
  int unsigned      all_rise;
  logic [LANES-1:0] prev_active;
  logic             prev_all;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_bits[l] = 0; m_mode[l] = M_SEARCH; m_comma[l] = 0; m_loss[l] = 0; m_anchor[l] = 0;
    end
    exp_data = '0; exp_valid = '0; exp_active = '0;
  endtask

  task automatic model_step(input logic [LANES-1:0] bits, input logic en);
    edge_t++;
    for (int l = 0; l < LANES; l++) begin
      int unsigned w;
      bit          word_end;
      w         = ((m_bits[l] << 1) | 32'(bits[l])) & WMASK;
      m_bits[l] = w;
      word_end  = (m_mode[l] != M_SEARCH) && (((edge_t - m_anchor[l]) % WIDTH) == 0);
      exp_valid[l] = 1'b0;
      if (!en) begin
        m_mode[l] = M_SEARCH; m_comma[l] = 0; m_loss[l] = 0;
      end else if (m_mode[l] == M_SEARCH) begin
        if (w == 32'(COMMA)) begin
          m_anchor[l] = edge_t;
          m_comma[l]  = 1;
          m_loss[l]   = 0;
          m_mode[l]   = (LOCK_COUNT == 1) ? M_LOCKED : M_ALIGN;
        end
      end else if (m_mode[l] == M_ALIGN) begin
        if (word_end) begin
          if (w == 32'(COMMA)) begin
            m_comma[l]++;
            if (m_comma[l] == LOCK_COUNT) begin
              m_mode[l] = M_LOCKED; m_loss[l] = 0;
            end
          end else begin
            m_mode[l] = M_SEARCH; m_comma[l] = 0;
          end
        end
      end else begin
        if (word_end) begin
          if (w == 32'(COMMA)) m_loss[l] = 0;
          else begin
            exp_data[l*WIDTH +: WIDTH] = w[WIDTH-1:0];
            exp_valid[l] = 1'b1;
          end
        end else if (w == 32'(COMMA)) begin
          m_loss[l]++;
          if (m_loss[l] >= LOSS_COUNT) begin
            m_mode[l] = M_SEARCH; m_loss[l] = 0; m_comma[l] = 0;
          end
        end
      end
      exp_active[l] = (m_mode[l] == M_LOCKED);
    end
  endtask

  task automatic phase_start();
    pcyc = 0; all_rise = 0;
    for (int l = 0; l < LANES; l++) begin
      rise_cyc[l] = 0; first_vcyc[l] = 0; vcount[l] = 0; last_word[l] = 0;
    end
    prev_active = bus.active;
    prev_all    = bus.all_active;
  endtask

  task automatic push_word(input int l, input logic [WIDTH-1:0] w);
    for (int b = WIDTH - 1; b >= 0; b--) lane_q[l].push_back(w[b]);
  endtask

  task automatic push_bits(input int l, input int n, input bit rnd);
    for (int k = 0; k < n; k++) lane_q[l].push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  function automatic bit pending();
    pending = 1'b0;
    for (int l = 0; l < LANES; l++) if (lane_q[l].size() > 0) pending = 1'b1;
  endfunction

  task automatic step();
    logic [LANES-1:0] bits;
    bits = '0;
    for (int l = 0; l < LANES; l++)
      if (lane_q[l].size() > 0) bits[l] = lane_q[l].pop_front();
    bus.serial_in = bits;
    model_step(bits, enable);
    @(posedge clk_8f);
    #1;
    pcyc++;
    check_val("data_out",   bus.data_out,   exp_data);
    check_val("valid_out",  bus.valid_out,  exp_valid);
    check_val("active",     bus.active,     exp_active);
    check_val("all_active", bus.all_active, &exp_active);
    for (int l = 0; l < LANES; l++) begin
      if (bus.active[l] && !prev_active[l] && rise_cyc[l] == 0) rise_cyc[l] = pcyc;
      if (bus.valid_out[l]) begin
        vcount[l]++;
        last_word[l] = 32'(bus.data_out[l*WIDTH +: WIDTH]);
        if (first_vcyc[l] == 0) first_vcyc[l] = pcyc;
      end
    end
    if (bus.all_active && !prev_all && all_rise == 0) all_rise = pcyc;
    prev_active = bus.active;
    prev_all    = bus.all_active;
  endtask

  task automatic run_all();
    while (pending()) step();
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #3 reset_L = 1'b0;
    #1;
    model_reset();
    for (int l = 0; l < LANES; l++) lane_q[l].delete();
    check_val("rst_data",   bus.data_out,   exp_data);
    check_val("rst_valid",  bus.valid_out,  exp_valid);
    check_val("rst_active", bus.active,     exp_active);
    check_val("rst_all",    bus.all_active, 1'b0);
    bus.serial_in = '0;
    repeat (2) @(posedge clk_8f);
    #1 reset_L = 1'b1;
    enable = 1'b1;
  endtask

  task automatic enable_drop();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  initial begin
    bus.serial_in = '0;
    model_reset();
    #2;
    check_val("init_data",   bus.data_out,   exp_data);
    check_val("init_valid",  bus.valid_out,  exp_valid);
    check_val("init_active", bus.active,     exp_active);
    check_val("init_all",    bus.all_active, 1'b0);
    repeat (2) @(posedge clk_8f);
    #1 reset_L = 1'b1;
    enable = 1'b1;

    // Lock on lane 0 only; lane 1 idle.
    phase_start();
    repeat (4) push_word(0, COMMA);
    push_word(0, 8'hDD);
    run_all();
    check_val("lock_edge",   rise_cyc[0],   32);
    check_val("first_valid", first_vcyc[0], 40);
    check_val("first_word",  last_word[0],  32'hDD);
    check_val("lane1_idle",  bus.active[1], 1'b0);

    // Both lanes, lane 1 offset by 3 bits, then streaming with a comma on lane 1.
    do_reset();
    phase_start();
    push_bits(1, 3, 1'b0);
    for (int l = 0; l < LANES; l++) repeat (4) push_word(l, COMMA);
    push_word(0, 8'hDD); push_word(0, 8'hEE); push_word(0, 8'hFF); push_word(0, 8'h01);
    push_word(1, COMMA); push_word(1, 8'hBB); push_word(1, 8'hAA); push_word(1, 8'h99);
    run_all();
    check_val("lock0_edge",  rise_cyc[0], 32);
    check_val("lock1_edge",  rise_cyc[1], 35);
    check_val("all_rise",    all_rise,    35);
    check_val("strobes0",    vcount[0],   4);
    check_val("strobes1",    vcount[1],   3);
    check_val("last_word1",  last_word[1], 32'h99);

    // Enable drop, 3 commas are not enough, then broken alignment and relock.
    do_reset();
    repeat (4) push_word(0, COMMA);
    push_word(0, 8'hDD);
    run_all();
    enable_drop();
    check_val("en_drop_active", bus.active[0], 1'b0);
    repeat (3) push_word(0, COMMA);
    push_word(0, 8'hDD);
    run_all();
    check_val("three_commas_nolock", bus.active[0], 1'b0);
    push_word(0, COMMA); push_word(0, COMMA); push_word(0, 8'h55);
    repeat (4) push_word(0, COMMA);
    push_word(0, 8'h3C);
    phase_start();
    run_all();
    check_val("relock_after_break", bus.active[0], 1'b1);
    check_val("relock_word",        last_word[0],  32'h3C);

    // Loss: off-boundary commas; an aligned comma in between resets the count.
    do_reset();
    repeat (4) push_word(0, COMMA);
    push_word(0, 8'hDD);
    push_bits(0, 1, 1'b0); push_word(0, COMMA); push_word(0, COMMA);
    push_bits(0, 7, 1'b0); push_word(0, COMMA);
    run_all();
    check_val("loss_cleared_locked", bus.active[0], 1'b1);
    push_bits(0, 1, 1'b0);
    repeat (3) push_word(0, COMMA);
    run_all();
    check_val("loss_dropped", bus.active[0], 1'b0);

    // Randomised word streams with slips and occasional enable drops.
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int l = 0; l < LANES; l++) begin
        push_bits(l, $urandom_range(0, WIDTH - 1), 1'b1);
        for (int k = 0; k < 40; k++) begin
          int unsigned r;
          r = $urandom_range(0, 9);
          if (r < 5)      push_word(l, COMMA);
          else if (r < 9) push_word(l, WIDTH'($urandom_range(0, WMASK)));
          else            push_bits(l, $urandom_range(1, WIDTH - 1), 1'b1);
        end
      end
      while (pending()) begin
        enable = ($urandom_range(0, 99) != 0);
        step();
      end
      enable = 1'b1;
    end

    // Reset mid-word on locked lanes discards the partial word.
    do_reset();
    for (int l = 0; l < LANES; l++) begin
      repeat (4) push_word(l, COMMA);
      push_word(l, 8'hA5);
    end
    push_bits(0, 3, 1'b1);
    run_all();
    check_val("pre_reset_active", bus.active, 2'b11);
    do_reset();
    phase_start();
    repeat (12) step();
    check_val("post_reset_nostrobe", vcount[0] + vcount[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
